// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, double-dabble adjust constants and a digit-count helper.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } bcd_state_t;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ        = 4'd3;

   // Widest digit field the helper below can inspect.
   localparam int BCD_MAX_DIGITS = 16;

   // Index of the highest nonzero digit among the low n_digits digits, plus one.
   // An all-zero field still counts as one significant digit.
   function automatic int bcd_ndigits(input logic [4*BCD_MAX_DIGITS-1:0] bcd,
                                      input int n_digits);
      int n;
      n = 1;
      for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
         if (i < n_digits && bcd[4*i +: 4] != 4'd0) n = i + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit of the shift-and-add-3 step: digits of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   assign adjusted = (digit >= BCD_ADJ_THRESH) ? (digit + BCD_ADJ) : digit;

endmodule

// File: rtl/seq_binary_to_bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock, with
// valid/ready on both sides, sign handling, overflow and digit count.
module seq_binary_to_bcd
   import bcd_pkg::*;
#(
   parameter int W_BIN    = 14,
   parameter int N_DIGITS = 5,
   parameter int SIGNED   = 0
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [W_BIN-1:0]              i_val,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [4*N_DIGITS-1:0]         o_bcd,
   output logic                          o_neg,
   output logic [$clog2(N_DIGITS+1)-1:0] o_ndigits,
   output logic                          o_overflow,
   output logic [1:0]                    o_state
);

   // Handshake: a word moves on any rising edge where its valid and ready are
   // both high; the sender holds data and valid until then, ready may drop freely.

   localparam int BW    = 4 * N_DIGITS;
   localparam int NDW   = $clog2(N_DIGITS + 1);
   localparam int CW    = $clog2(W_BIN);
   localparam int EXT_W = 4 * BCD_MAX_DIGITS;

   bcd_state_t        state_q;
   logic [CW-1:0]     cnt_q;
   logic [BW-1:0]     bcd_q;
   logic [W_BIN-1:0]  bin_q;
   logic              neg_q;
   logic              ovf_q;

   logic [BW-1:0]     bcd_adj;
   logic [BW-1:0]     bcd_shift;
   logic [W_BIN-1:0]  bin_shift;
   logic              ovf_next;
   logic              sign_in;
   logic [W_BIN-1:0]  mag_in;

   for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit    (bcd_q[4*g +: 4]),
         .adjusted (bcd_adj[4*g +: 4])
      );
   end

   // The bit leaving the top digit would belong to a digit we do not keep.
   assign bcd_shift = {bcd_adj[BW-2:0], bin_q[W_BIN-1]};
   assign bin_shift = {bin_q[W_BIN-2:0], 1'b0};
   assign ovf_next  = ovf_q | bcd_adj[BW-1];

   // The most negative input negates to itself, which reads correctly as unsigned.
   assign sign_in = (SIGNED != 0) && i_val[W_BIN-1];
   assign mag_in  = sign_in ? (~i_val + W_BIN'(1)) : i_val;

   assign o_ready = (state_q == ST_IDLE);
   assign o_state = state_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bcd_q      <= '0;
         bin_q      <= '0;
         neg_q      <= 1'b0;
         ovf_q      <= 1'b0;
         o_valid    <= 1'b0;
         o_bcd      <= '0;
         o_neg      <= 1'b0;
         o_ndigits  <= NDW'(1);
         o_overflow <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  bin_q   <= mag_in;
                  neg_q   <= sign_in;
                  bcd_q   <= '0;
                  ovf_q   <= 1'b0;
                  cnt_q   <= CW'(W_BIN - 1);
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               bcd_q <= bcd_shift;
               bin_q <= bin_shift;
               ovf_q <= ovf_next;
               if (cnt_q == '0) begin
                  state_q    <= ST_DONE;
                  o_valid    <= 1'b1;
                  o_bcd      <= bcd_shift;
                  o_neg      <= neg_q;
                  o_overflow <= ovf_next;
                  o_ndigits  <= ovf_next ? NDW'(N_DIGITS)
                                         : NDW'(bcd_ndigits(EXT_W'(bcd_shift), N_DIGITS));
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            ST_DONE: begin
               // New input words wait here; only the output handshake matters.
               if (i_ready) begin
                  state_q <= ST_IDLE;
                  o_valid <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
